run_sequencer: RTL and testbench
================================

Name: run_sequencer

Overview:
- Sequences one program run of the single-cycle accumulator core.
- Arbitrates the core's 256-byte data memory port between a host loader/readback interface and the core.
- The host preloads memory, pulses start, then waits for completion or timeout and reads results back.
- Sits between the host/testbench and the core top level; it drives the core's req and observes its done.

Parameters:
ADDR_WIDTH, 8, data memory address width (256 bytes)
DATA_WIDTH, 8, data memory word width
CNT_WIDTH, 16, cycle counter width
MAX_CYCLES, 4096, RUN-cycle limit before timeout; 0 disables timeout

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
host_start  in  1  begin a run (sampled in IDLE/DONE)
host_abort  in  1  abandon run or clear result, return to IDLE
host_mem_req  in  1  host memory access request
host_mem_we  in  1  host write (1) / read (0)
host_mem_addr  in  ADDR_WIDTH  host address
host_mem_wdata  in  DATA_WIDTH  host write data
host_mem_gnt  out  1  host access performed this cycle
host_mem_rdata  out  DATA_WIDTH  registered host read data
host_mem_rvalid  out  1  host_mem_rdata valid (one cycle)
core_req  out  1  core req (PC reset/park)
core_done  in  1  core halt indication
core_mem_we  in  1  core data write enable
core_mem_addr  in  ADDR_WIDTH  core data address
core_mem_wdata  in  DATA_WIDTH  core write data
mem_we  out  1  to data memory
mem_addr  out  ADDR_WIDTH  to data memory
mem_wdata  out  DATA_WIDTH  to data memory
mem_rdata  in  DATA_WIDTH  combinational read data for mem_addr
busy  out  1  state is START or RUN
run_done  out  1  last run ended by core_done
timeout  out  1  last run ended by cycle limit
cycle_count  out  CNT_WIDTH  RUN cycles of current/last run

Behaviour:
- Reset (reset_n=0, async): state=IDLE, core_req=1, cycle_count=0, run_done=0, timeout=0, host_mem_rvalid=0, host_mem_rdata=0.
- FSM states: IDLE, START, RUN, DONE.
- IDLE:
  - core_req=1 (core parked at PC 0); host owns memory.
  - host_start → START.
- START:
  - Exactly one cycle; core_req=1; memory writes blocked (mem_we=0).
  - On entry, cycle_count, run_done and timeout clear to 0.
  - Always → RUN.
- RUN:
  - core_req=0; core owns memory.
  - cycle_count increments every RUN cycle, including the cycle core_done is seen; saturates at all-ones.
  - Priority, highest first:
    1. host_abort → IDLE (flags stay 0).
    2. core_done=1 → DONE, run_done=1.
    3. MAX_CYCLES≠0 and pre-increment cycle_count==MAX_CYCLES-1 → DONE, timeout=1. cycle_count then reads MAX_CYCLES.
  - core_done and the limit in the same cycle: run_done=1, timeout=0.
- DONE:
  - core_req=0 (core halted by its own done); host owns memory.
  - Flags and cycle_count hold.
  - host_abort → IDLE, clearing flags and count. host_start → START. Abort wins if both are asserted.
- Memory mux:
  - Host-owned states (IDLE, DONE): mem_addr/mem_wdata=host signals; mem_we=host_mem_req&host_mem_we; host_mem_gnt=host_mem_req.
  - START/RUN: mem_addr/mem_wdata=core signals; mem_we=core_mem_we only in RUN. host_mem_gnt=0, so host requests stall and must be held.
- Host read:
  - Granted read (gnt=1, we=0) captures mem_rdata at that edge.
  - host_mem_rvalid=1 for the next cycle only. A granted write gives rvalid=0.
- host_start together with a granted host access in IDLE/DONE: the access completes this cycle and the state moves to START.
- Reset mid-run: immediate return to IDLE defaults; any memory write in flight that cycle is undefined.
- core_done is ignored outside RUN.

Test Plan:
- Reset then idle → core_req=1, busy=0, run_done=0, timeout=0, cycle_count=0, mem_we=0 with no host_mem_req.
- Host writes 0x5A to addr 0x10, then reads addr 0x10 → gnt=1 both cycles; rvalid=1 with rdata=0x5A the cycle after the read grant.
- host_start; core model asserts core_done on its 7th RUN cycle → START for 1 cycle with core_req=1, then busy for 8 cycles total, run_done=1, cycle_count=7, timeout=0, core_req=0.
- MAX_CYCLES=16, core never done → DONE after 16 RUN cycles; timeout=1, cycle_count=16. Repeat with core_done in the 16th cycle → run_done=1, timeout=0.
- host_mem_req write held during RUN while core_mem_we=1 to addr 0x20 → host_mem_gnt=0, mem_addr=0x20 from core. The host write is granted the first DONE cycle.
- host_abort in RUN, and reset_n low mid-RUN → IDLE next cycle (abort) or immediately (reset); flags 0, core_req=1. A following host_start runs normally.

Source files
------------

// File: rtl/run_sequencer_if.sv
// Host load/readback bus into the run sequencer's shared data memory port.
// The host is the master; the sequencer grants the access and returns registered read data.
interface run_sequencer_if #(
   parameter int unsigned AddrWidth = 8,
   parameter int unsigned DataWidth = 8
);
   logic                 req;
   logic                 we;
   logic [AddrWidth-1:0] addr;
   logic [DataWidth-1:0] wdata;
   logic                 gnt;
   logic [DataWidth-1:0] rdata;
   logic                 rvalid;

   modport master (
      output req, we, addr, wdata,
      input  gnt, rdata, rvalid
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, rdata, rvalid
   );
endinterface

// File: rtl/run_sequencer.sv
// Sequences one run of the accumulator core and arbitrates the data memory port
// between the host (idle/done) and the core (start/run).
module run_sequencer #(
   parameter int unsigned AddrWidth = 8,
   parameter int unsigned DataWidth = 8,
   parameter int unsigned CntWidth  = 16,
   parameter int unsigned MaxCycles = 4096
) (
   input  logic                 clk,
   input  logic                 reset_n,
   run_sequencer_if.slave       host_mem,
   input  logic                 host_start_i,
   input  logic                 host_abort_i,
   output logic                 core_req_o,
   input  logic                 core_done_i,
   input  logic                 core_mem_we_i,
   input  logic [AddrWidth-1:0] core_mem_addr_i,
   input  logic [DataWidth-1:0] core_mem_wdata_i,
   output logic                 mem_we_o,
   output logic [AddrWidth-1:0] mem_addr_o,
   output logic [DataWidth-1:0] mem_wdata_o,
   input  logic [DataWidth-1:0] mem_rdata_i,
   output logic                 busy_o,
   output logic                 run_done_o,
   output logic                 timeout_o,
   output logic [CntWidth-1:0]  cycle_count_o
);

   typedef enum logic [1:0] {StIdle, StStart, StRun, StDone} state_e;

   localparam logic [CntWidth-1:0] LastCnt = CntWidth'(MaxCycles - 1);

   state_e               state_q, state_d;
   logic [CntWidth-1:0]  cnt_q, cnt_d, cnt_inc;
   logic                 run_done_q, run_done_d;
   logic                 timeout_q, timeout_d;
   logic [DataWidth-1:0] rdata_q;
   logic                 rvalid_q;
   logic                 host_owns;
   logic                 limit_hit;

   assign host_owns = (state_q == StIdle) || (state_q == StDone);
   assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
   assign limit_hit = (MaxCycles != 0) && (cnt_q == LastCnt);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      run_done_d = run_done_q;
      timeout_d  = timeout_q;
      unique case (state_q)
         StIdle: begin
            if (host_start_i) begin
               state_d    = StStart;
               cnt_d      = '0;
               run_done_d = 1'b0;
               timeout_d  = 1'b0;
            end
         end
         StStart: state_d = StRun;
         StRun: begin
            cnt_d = cnt_inc;
            if (host_abort_i) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (core_done_i) begin
               state_d    = StDone;
               run_done_d = 1'b1;
            end else if (limit_hit) begin
               state_d   = StDone;
               timeout_d = 1'b1;
            end
         end
         StDone: begin
            // Abort beats start; both clear the result of the previous run.
            if (host_abort_i || host_start_i) begin
               state_d    = host_abort_i ? StIdle : StStart;
               cnt_d      = '0;
               run_done_d = 1'b0;
               timeout_d  = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      host_mem.gnt = host_owns && host_mem.req;
      if (host_owns) begin
         mem_addr_o  = host_mem.addr;
         mem_wdata_o = host_mem.wdata;
         mem_we_o    = host_mem.req && host_mem.we;
      end else begin
         mem_addr_o  = core_mem_addr_i;
         mem_wdata_o = core_mem_wdata_i;
         mem_we_o    = (state_q == StRun) && core_mem_we_i;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         run_done_q <= 1'b0;
         timeout_q  <= 1'b0;
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         run_done_q <= run_done_d;
         timeout_q  <= timeout_d;
         rvalid_q   <= host_mem.gnt && !host_mem.we;
         if (host_mem.gnt && !host_mem.we) begin
            rdata_q <= mem_rdata_i;
         end
      end
   end

   assign host_mem.rdata  = rdata_q;
   assign host_mem.rvalid = rvalid_q;
   assign core_req_o      = (state_q == StIdle) || (state_q == StStart);
   assign busy_o          = (state_q == StStart) || (state_q == StRun);
   assign run_done_o      = run_done_q;
   assign timeout_o       = timeout_q;
   assign cycle_count_o   = cnt_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Randomized bench for run_sequencer: run outcomes come from a run-length model,
// memory contents from a shadow array of every host and core write.
module tb_run_sequencer;
   localparam int unsigned Max = 16;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        host_start, host_abort;
   logic        core_req, core_done, core_mem_we;
   logic [7:0]  core_mem_addr, core_mem_wdata;
   logic        mem_we;
   logic [7:0]  mem_addr, mem_wdata, mem_rdata;
   logic        busy, run_done, timeout;
   logic [15:0] cycle_count;

   logic [7:0]  mem     [256];
   logic [7:0]  ref_mem [256];
   bit          written [256];
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   run_sequencer_if #(.AddrWidth(8), .DataWidth(8)) hif ();

   run_sequencer #(
      .AddrWidth(8), .DataWidth(8), .CntWidth(16), .MaxCycles(Max)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .host_mem         (hif),
      .host_start_i     (host_start),
      .host_abort_i     (host_abort),
      .core_req_o       (core_req),
      .core_done_i      (core_done),
      .core_mem_we_i    (core_mem_we),
      .core_mem_addr_i  (core_mem_addr),
      .core_mem_wdata_i (core_mem_wdata),
      .mem_we_o         (mem_we),
      .mem_addr_o       (mem_addr),
      .mem_wdata_o      (mem_wdata),
      .mem_rdata_i      (mem_rdata),
      .busy_o           (busy),
      .run_done_o       (run_done),
      .timeout_o        (timeout),
      .cycle_count_o    (cycle_count)
   );

   always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
   assign mem_rdata = mem[mem_addr];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic host_write(input logic [7:0] a, input logic [7:0] d);
      hif.req = 1'b1; hif.we = 1'b1; hif.addr = a; hif.wdata = d;
      #1 check_eq("wr_gnt", hif.gnt, 1);
      check_eq("wr_mem_we", mem_we, 1);
      step();
      hif.req = 1'b0; hif.we = 1'b0;
      ref_mem[a] = d; written[a] = 1'b1;
      check_eq("wr_rvalid", hif.rvalid, 0);
   endtask

   task automatic host_read(input logic [7:0] a);
      hif.req = 1'b1; hif.we = 1'b0; hif.addr = a;
      #1 check_eq("rd_gnt", hif.gnt, 1);
      check_eq("rd_mem_we", mem_we, 0);
      step();
      hif.req = 1'b0;
      check_eq("rd_rvalid", hif.rvalid, 1);
      check_eq("rd_data", hif.rdata, ref_mem[a]);
      step();
      check_eq("rd_rvalid_drop", hif.rvalid, 0);
   endtask

   // Core model asserts done in RUN cycle k; k > Max means it never finishes in time.
   task automatic do_run(input int k, input bit core_wr);
      int len;
      len = (k <= Max) ? k : Max;
      host_start = 1'b1;
      step();
      host_start = 1'b0;
      core_mem_we = 1'b1; core_mem_addr = 8'($urandom); core_mem_wdata = 8'($urandom);
      #1 check_eq("start_busy", busy, 1);
      check_eq("start_core_req", core_req, 1);
      check_eq("start_cnt", cycle_count, 0);
      check_eq("start_flags", {run_done, timeout}, 0);
      check_eq("start_mem_we_blocked", mem_we, 0);
      step();
      for (int c = 1; c <= len; c++) begin
         core_done = (c == k);
         core_mem_we = core_wr && ($urandom_range(0, 1) == 1);
         core_mem_addr = 8'($urandom);
         core_mem_wdata = 8'($urandom);
         if (core_mem_we) begin
            ref_mem[core_mem_addr] = core_mem_wdata;
            written[core_mem_addr] = 1'b1;
         end
         #1 check_eq("run_core_req", core_req, 0);
         check_eq("run_busy", busy, 1);
         check_eq("run_mem_we", mem_we, core_mem_we);
         check_eq("run_mem_addr", mem_addr, core_mem_addr);
         step();
      end
      core_done = 1'b0; core_mem_we = 1'b0;
      #1 check_eq("end_busy", busy, 0);
      check_eq("end_core_req", core_req, 0);
      check_eq("end_run_done", run_done, (k <= Max));
      check_eq("end_timeout", timeout, (k > Max));
      check_eq("end_cnt", cycle_count, len);
   endtask

   initial begin
      reset_n = 1'b0; host_start = 1'b0; host_abort = 1'b0;
      core_done = 1'b0; core_mem_we = 1'b0; core_mem_addr = '0; core_mem_wdata = '0;
      hif.req = 1'b0; hif.we = 1'b0; hif.addr = '0; hif.wdata = '0;
      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = '0; written[i] = 1'b0;
      end
      step(); step();
      reset_n = 1'b1;
      step();
      check_eq("rst_core_req", core_req, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_flags", {run_done, timeout}, 0);
      check_eq("rst_cnt", cycle_count, 0);
      check_eq("rst_mem_we", mem_we, 0);
      check_eq("rst_rd", {hif.rvalid, hif.rdata}, 0);

      host_write(8'h10, 8'h5A);
      host_read(8'h10);

      // core_done outside RUN has no effect
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      check_eq("idle_done_ignored", {busy, run_done}, 0);

      do_run(7, 1'b0);
      do_run(20, 1'b0);
      do_run(16, 1'b0);

      // Host write held across a run is granted only once the run is done
      host_start = 1'b1;
      step();
      host_start = 1'b0;
      hif.req = 1'b1; hif.we = 1'b1; hif.addr = 8'h30; hif.wdata = 8'h77;
      #1 check_eq("hold_start_gnt", hif.gnt, 0);
      step();
      core_mem_we = 1'b1; core_mem_addr = 8'h20; core_mem_wdata = 8'hC3;
      #1 check_eq("hold_run_gnt", hif.gnt, 0);
      check_eq("hold_mem_addr", mem_addr, 8'h20);
      check_eq("hold_mem_wdata", mem_wdata, 8'hC3);
      check_eq("hold_mem_we", mem_we, 1);
      step();
      core_mem_we = 1'b0; core_done = 1'b1;
      step();
      core_done = 1'b0;
      check_eq("hold_done_gnt", hif.gnt, 1);
      check_eq("hold_done_addr", mem_addr, 8'h30);
      check_eq("hold_done_cnt", cycle_count, 2);
      step();
      hif.req = 1'b0; hif.we = 1'b0;
      ref_mem[8'h20] = 8'hC3; written[8'h20] = 1'b1;
      ref_mem[8'h30] = 8'h77; written[8'h30] = 1'b1;
      host_read(8'h20);
      host_read(8'h30);

      // Abort and start together in DONE: abort wins and clears the result
      host_abort = 1'b1; host_start = 1'b1;
      step();
      host_abort = 1'b0; host_start = 1'b0;
      check_eq("done_abort_busy", busy, 0);
      check_eq("done_abort_core_req", core_req, 1);
      check_eq("done_abort_cnt", cycle_count, 0);
      check_eq("done_abort_flags", {run_done, timeout}, 0);

      // Abort mid-run
      host_start = 1'b1;
      step();
      host_start = 1'b0;
      step(); step();
      host_abort = 1'b1;
      step();
      host_abort = 1'b0;
      check_eq("abort_busy", busy, 0);
      check_eq("abort_core_req", core_req, 1);
      check_eq("abort_flags", {run_done, timeout}, 0);
      do_run(5, 1'b1);

      // Asynchronous reset mid-run
      host_start = 1'b1;
      step();
      host_start = 1'b0;
      step(); step();
      reset_n = 1'b0;
      #1 check_eq("rst_mid_core_req", core_req, 1);
      check_eq("rst_mid_busy", busy, 0);
      check_eq("rst_mid_flags", {run_done, timeout}, 0);
      check_eq("rst_mid_cnt", cycle_count, 0);
      step();
      reset_n = 1'b1;
      step();
      do_run(3, 1'b1);

      for (int r = 0; r < 8; r++) begin
         do_run($urandom_range(1, 24), 1'b1);
      end

      for (int a = 0; a < 256; a++) begin
         if (written[a]) host_read(8'(a));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
